// File: rtl/async_bus_master_pkg.sv
// Shared definitions for the asynchronous register-bus master and its slave:
// default bus widths and the bus-cycle state encoding.
package async_bus_pkg;

    localparam int DEF_ADDR_WIDTH = 24;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BE_WIDTH   = DEF_DATA_WIDTH / 8;

    // One bus cycle walks IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } bus_state_e;

endpackage

// File: rtl/async_bus_master_if.sv
// Request/response handshake plus external bus pins of the register-bus master.
// The master modport is the initiator view; the slave modport is everything on
// the other side (command logic and register-file slave).
interface async_bus_master_if
    import async_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BE_WIDTH   = DEF_BE_WIDTH
) ();

    // Request side
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [BE_WIDTH-1:0]   req_be;

    // Response side
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    // External bus
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ws_n;
    logic                  rs_n;
    logic [BE_WIDTH-1:0]   be;
    logic                  as;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_be, data_in,
        output req_ready, rsp_valid, rsp_rdata,
        output address, data_out, ws_n, rs_n, be, as
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_be, data_in,
        input  req_ready, rsp_valid, rsp_rdata,
        input  address, data_out, ws_n, rs_n, be, as
    );

endinterface

// File: rtl/async_bus_master_phase_timer.sv
// Loadable down-counter shared by the SETUP, STROBE and HOLD phases.
// It stops at zero rather than wrapping, so an idle master sees a steady
// zero flag.
module phase_timer #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    output logic                 zero_o
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Load wins over decrement; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/async_bus_master.sv
// Initiator for the asynchronous register bus. Turns one accepted request
// into a setup / strobe / hold bus cycle with programmable phase lengths and
// returns a single-cycle response. Every output comes straight from a flop.
module async_bus_master
    import async_bus_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int BE_WIDTH      = DEF_BE_WIDTH,
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 8,
    parameter int HOLD_CYCLES   = 2,
    parameter int CNT_WIDTH     = 4
) (
    input  logic               clk,
    input  logic               rst,
    async_bus_master_if.master bus
);

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_WIDTH-1:0] SETUP_LOAD  = CNT_WIDTH'(SETUP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STROBE_LOAD = CNT_WIDTH'(STROBE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD   = CNT_WIDTH'(HOLD_CYCLES - 1);

    bus_state_e            state_q,     state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  as_q,        as_d;
    logic                  ws_n_q,      ws_n_d;
    logic                  rs_n_q,      rs_n_d;
    logic [ADDR_WIDTH-1:0] address_q,   address_d;
    logic [DATA_WIDTH-1:0] data_out_q,  data_out_d;
    logic [BE_WIDTH-1:0]   be_q,        be_d;
    logic                  write_q,     write_d;

    logic                  tmr_load;
    logic [CNT_WIDTH-1:0]  tmr_load_val;
    logic                  tmr_zero;

    phase_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .zero_o     (tmr_zero)
    );

    // Next-state logic: each phase ends when the shared timer reaches zero.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        as_d         = as_q;
        ws_n_d       = ws_n_q;
        rs_n_d       = rs_n_q;
        address_d    = address_q;
        data_out_d   = data_out_q;
        be_d         = be_q;
        write_d      = write_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    write_d      = bus.req_write;
                    address_d    = bus.req_addr;
                    be_d         = bus.req_be;
                    data_out_d   = bus.req_write ? bus.req_wdata : '0;
                    as_d         = 1'b1;
                    req_ready_d  = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_load_val = SETUP_LOAD;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    if (write_q) begin
                        ws_n_d = 1'b0;
                    end else begin
                        rs_n_d = 1'b0;
                    end
                    tmr_load     = 1'b1;
                    tmr_load_val = STROBE_LOAD;
                    state_d      = STROBE;
                end
            end
            STROBE: begin
                if (tmr_zero) begin
                    // Read data is taken on the same edge the strobe is released.
                    if (!write_q) begin
                        rsp_rdata_d = bus.data_in;
                    end
                    ws_n_d       = 1'b1;
                    rs_n_d       = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = HOLD_LOAD;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    // Ready rises with the response so a new request can be
                    // accepted in the response cycle.
                    as_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any bus cycle in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            as_q        <= 1'b0;
            ws_n_q      <= 1'b1;
            rs_n_q      <= 1'b1;
            address_q   <= '0;
            data_out_q  <= '0;
            be_q        <= '0;
            write_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            as_q        <= as_d;
            ws_n_q      <= ws_n_d;
            rs_n_q      <= rs_n_d;
            address_q   <= address_d;
            data_out_q  <= data_out_d;
            be_q        <= be_d;
            write_q     <= write_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.as        = as_q;
    assign bus.ws_n      = ws_n_q;
    assign bus.rs_n      = rs_n_q;
    assign bus.address   = address_q;
    assign bus.data_out  = data_out_q;
    assign bus.be        = be_q;

endmodule

// File: tb/tb_async_bus_master.sv
// Bench for async_bus_master. A timeline model (expected outputs as a function
// of edges elapsed since acceptance) tracks the default 2/8/2 instance every
// cycle; a second 1/1/1 instance gets short directed transactions.
module tb_async_bus_master;
    import async_bus_pkg::*;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int S  = 2;
    localparam int T  = 8;
    localparam int H  = 2;
    localparam int L  = S + T + H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    async_bus_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus1();
    async_bus_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus2();

    async_bus_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
        .SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H), .CNT_WIDTH(4)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    async_bus_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
        .SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1), .CNT_WIDTH(4)
    ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit            m_busy = 0;
    int            m_t    = 0;
    bit            m_acc  = 0;
    bit            m_wr   = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_dout = '0;
    logic [BW-1:0] m_be   = '0;
    logic [DW-1:0] m_rdata = '0;
    bit            rand_din = 0;

    function automatic bit m_active();
        return m_busy && (m_t < L);
    endfunction

    task automatic model_edge();
        m_acc = 0;
        if (rst) begin
            m_busy = 0; m_t = 0; m_wr = 0;
            m_addr = '0; m_dout = '0; m_be = '0; m_rdata = '0;
        end else if (!m_active()) begin
            if (bus1.req_valid) begin
                m_acc  = 1;
                m_busy = 1;
                m_t    = 0;
                m_wr   = bus1.req_write;
                m_addr = bus1.req_addr;
                m_be   = bus1.req_be;
                m_dout = bus1.req_write ? bus1.req_wdata : '0;
            end else begin
                m_busy = 0;
            end
        end else begin
            if (m_t == S + T - 1 && !m_wr) m_rdata = bus1.data_in;
            m_t++;
        end
    endtask

    task automatic compare_all();
        bit act;
        bit strobe;
        act    = m_active();
        strobe = act && (m_t >= S) && (m_t < S + T);
        check_val("req_ready", 64'(bus1.req_ready), 64'(!act));
        check_val("rsp_valid", 64'(bus1.rsp_valid), 64'(m_busy && m_t == L));
        check_val("as",        64'(bus1.as),        64'(act));
        check_val("ws_n",      64'(bus1.ws_n),      64'(!(strobe && m_wr)));
        check_val("rs_n",      64'(bus1.rs_n),      64'(!(strobe && !m_wr)));
        check_val("address",   64'(bus1.address),   64'(m_addr));
        check_val("data_out",  64'(bus1.data_out),  64'(m_dout));
        check_val("be",        64'(bus1.be),        64'(m_be));
        check_val("rsp_rdata", 64'(bus1.rsp_rdata), 64'(m_rdata));
    endtask

    task automatic step();
        if (rand_din) bus1.data_in = $urandom;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] b, input bit hold_valid);
        bit done = 0;
        bus1.req_write = wr;
        bus1.req_addr  = a;
        bus1.req_wdata = d;
        bus1.req_be    = b;
        bus1.req_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (m_acc) done = 1;
        end
        if (!done) check_val("accept_timeout", 64'd0, 64'd1);
        if (!hold_valid) bus1.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && m_active(); i++) step();
        if (m_active()) check_val("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_fast(input bit wr, input logic [DW-1:0] din);
        int edges = 0;
        int lo    = 0;
        bit got   = 0;
        bus2.req_write = wr;
        bus2.req_addr  = 24'h00ABCD;
        bus2.req_wdata = 32'h13572468;
        bus2.req_be    = 4'hF;
        bus2.data_in   = din;
        check_val("fast_ready", 64'(bus2.req_ready), 64'd1);
        bus2.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus2.req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!bus2.ws_n || !bus2.rs_n) lo++;
            if (bus2.rsp_valid) begin
                got = 1;
                break;
            end
            @(negedge clk);
            edges++;
        end
        check_val("fast_rsp_seen",  64'(got),   64'd1);
        check_val("fast_rsp_edges", 64'(edges), 64'd3);
        check_val("fast_strobe_lo", 64'(lo),    64'd1);
        if (!wr) check_val("fast_rdata", 64'(bus2.rsp_rdata), 64'(din));
        @(negedge clk);
        check_val("fast_rsp_once", 64'(bus2.rsp_valid), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int as_hi, ws_lo, rs_lo, rsp_cnt, rsp_at, ws_first, as_first;
        int gap, span;
        bit done;

        bus1.req_valid = 0; bus1.req_write = 0; bus1.req_addr = '0;
        bus1.req_wdata = '0; bus1.req_be = '0; bus1.data_in = '0;
        bus2.req_valid = 0; bus2.req_write = 0; bus2.req_addr = '0;
        bus2.req_wdata = '0; bus2.req_be = '0; bus2.data_in = '0;

        // Reset, then idle
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Directed write: measure pin timeline from the accept edge
        issue(1'b1, 24'h000010, 32'hDEADBEEF, 4'hF, 1'b0);
        as_hi = 0; ws_lo = 0; rs_lo = 0; rsp_cnt = 0; rsp_at = -1; ws_first = -1; as_first = -1;
        for (int i = 0; i < 16; i++) begin
            if (bus1.as) begin
                as_hi++;
                if (as_first < 0) as_first = i;
            end
            if (!bus1.ws_n) begin
                ws_lo++;
                if (ws_first < 0) ws_first = i;
            end
            if (!bus1.rs_n) rs_lo++;
            if (bus1.rsp_valid) begin
                rsp_cnt++;
                rsp_at = i;
            end
            if (i < 15) step();
        end
        check_val("wr_as_cycles",  64'(as_hi),              64'd12);
        check_val("wr_ws_cycles",  64'(ws_lo),              64'd8);
        check_val("wr_ws_offset",  64'(ws_first - as_first), 64'd2);
        check_val("wr_rs_cycles",  64'(rs_lo),              64'd0);
        check_val("wr_rsp_count",  64'(rsp_cnt),            64'd1);
        check_val("wr_rsp_edge",   64'(rsp_at),             64'd12);

        // Directed read: data_in changes right after the sampling edge
        bus1.data_in = 32'hCAFEF00D;
        issue(1'b0, 24'h000004, 32'h12345678, 4'hF, 1'b0);
        for (int i = 0; i < 40 && m_t < S + T; i++) step();
        bus1.data_in = 32'h0;
        for (int i = 0; i < 40 && !(m_busy && m_t == L); i++) step();
        check_val("rd_rsp_valid", 64'(bus1.rsp_valid), 64'd1);
        check_val("rd_rdata",     64'(bus1.rsp_rdata), 64'hCAFEF00D);
        check_val("rd_data_out",  64'(bus1.data_out),  64'd0);
        wait_idle();
        step();

        // Back-to-back with req_valid held high
        issue(1'b1, 24'h000020, 32'h11112222, 4'h3, 1'b1);
        bus1.req_write = 1'b0;
        bus1.req_addr  = 24'h000024;
        bus1.req_be    = 4'hC;
        bus1.data_in   = 32'h0BADF00D;
        gap = 0; span = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            span++;
            if (!bus1.as) gap++;
            if (m_acc) done = 1;
        end
        bus1.req_valid = 1'b0;
        check_val("b2b_accepted", 64'(done), 64'd1);
        check_val("b2b_as_gap",   64'(gap),  64'd1);
        check_val("b2b_span",     64'(span), 64'(L + 1));
        wait_idle();
        step();

        // Reset in the third strobe cycle aborts the write
        issue(1'b1, 24'h000030, 32'hA5A5A5A5, 4'hF, 1'b0);
        for (int i = 0; i < 40 && m_t < S + 2; i++) step();
        check_val("abort_in_strobe", 64'(bus1.ws_n), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("abort_ws_n",  64'(bus1.ws_n),      64'd1);
        check_val("abort_as",    64'(bus1.as),        64'd0);
        check_val("abort_ready", 64'(bus1.req_ready), 64'd1);
        check_val("abort_rsp",   64'(bus1.rsp_valid), 64'd0);
        repeat (L + 2) step();
        bus1.data_in = 32'h600DCAFE;
        issue(1'b0, 24'h000008, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 40 && !(m_busy && m_t == L); i++) step();
        check_val("post_abort_rsp",   64'(bus1.rsp_valid), 64'd1);
        check_val("post_abort_rdata", 64'(bus1.rsp_rdata), 64'h600DCAFE);
        wait_idle();

        // Randomized traffic against the timeline model
        rand_din = 1;
        for (int n = 0; n < 40; n++) begin
            int idle_gap;
            idle_gap = $urandom_range(0, 3);
            for (int g = 0; g < idle_gap; g++) step();
            issue(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), BW'($urandom), 1'b0);
        end
        wait_idle();
        rand_din = 0;
        step();

        // 1/1/1 instance
        run_fast(1'b1, 32'h0);
        run_fast(1'b0, 32'h5A5A1234);
        run_fast(1'b0, 32'h00C0FFEE);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/async_bus_master.md
# async_bus_master

Initiator side of the asynchronous ARM-style register bus. It accepts single read/write requests from on-chip logic and generates a complete bus cycle toward a register-file slave: address/select setup, strobe, and hold. Each phase lasts a parameterized number of clock cycles, so a slave that synchronizes its strobes through a shift register sees clean, stable pulses. Each completed cycle returns a one-cycle response with read data. It sits between the FPGA-side command logic and the external bus pins, or a loopback to an on-chip register file.

## Interface
- ADDR_WIDTH, 24, bus address width
- DATA_WIDTH, 32, bus data width
- BE_WIDTH, 4, byte-enable width (DATA_WIDTH/8)
- SETUP_CYCLES, 2, cycles address/be/data/as are stable before the strobe falls (≥1)
- STROBE_CYCLES, 8, cycles the strobe is held low (≥1; ≥ slave synchronizer depth plus margin)
- HOLD_CYCLES, 2, cycles address/as are held after the strobe rises (≥1)
- CNT_WIDTH, 4, phase counter width; each *_CYCLES ≤ 2^CNT_WIDTH
- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data
- req_be  in  BE_WIDTH  byte enables
- rsp_valid  out  1  one-cycle completion pulse (reads and writes)
- rsp_rdata  out  DATA_WIDTH  captured read data
- address  out  ADDR_WIDTH  bus address
- data_out  out  DATA_WIDTH  bus write data (to slave data_in)
- data_in  in  DATA_WIDTH  bus read data (from slave data_out)
- ws_n  out  1  write strobe, active low
- rs_n  out  1  read strobe, active low
- be  out  BE_WIDTH  bus byte enables
- as  out  1  chip select, active high

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. All outputs are registered.
- Reset values, applied on the edge where rst=1 from any state:
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0
  - as = 0, ws_n = 1, rs_n = 1, address = 0, data_out = 0, be = 0
- IDLE: req_ready = 1. On req_valid & req_ready:
  - latch the request
  - drive address = req_addr and be = req_be
  - drive data_out = req_wdata for a write, 0 for a read
  - set as = 1, load counter = SETUP_CYCLES-1, go to SETUP
- SETUP: counter decrements. At 0: drive ws_n = 0 (write) or rs_n = 0 (read), load STROBE_CYCLES-1, go to STROBE.
- STROBE: strobe held low. At 0:
  - read: rsp_rdata <= data_in on this edge
  - release the strobe to 1, load HOLD_CYCLES-1, go to HOLD
- HOLD: address, be, data_out and as held. At 0: as = 0, rsp_valid = 1, go to IDLE.
- rsp_valid is high for exactly one cycle. rsp_rdata holds its last read value and is unchanged by writes.
- req_valid outside IDLE is ignored; the requester holds the request until req_ready is seen.
- ws_n and rs_n are never both low. Strobes are low only while as = 1.
- Reads with be = 0 still perform a full bus cycle.
- The counter only loads and decrements to 0; it never wraps.

## Timing
- Request accepted at edge k; S/T/H = SETUP/STROBE/HOLD_CYCLES.
- as rises after edge k.
- Strobe falls after edge k+S and rises after edge k+S+T.
- Read data is sampled at edge k+S+T.
- as falls and rsp_valid is high after edge k+S+T+H, for one cycle.
- Defaults (2/8/2): rsp_valid 12 edges after accept; strobe low 8 cycles.
- req_ready is 1 in the rsp_valid cycle, so back-to-back acceptance is allowed. as is therefore low for at least 1 cycle between transactions.
- A reset mid-cycle aborts the transaction: no rsp_valid, and strobes/as go inactive on the reset edge.

## Structure
- Package async_bus_pkg holds:
  - the state enum (IDLE/SETUP/STROBE/HOLD)
  - default ADDR/DATA/BE widths shared with the register-file slave
- Sub-module phase_timer: loadable CNT_WIDTH down-counter with load, load value and zero flag. One instance is shared by all three phases.

## Test plan
- Reset, then idle: req_ready=1, as=0, ws_n=rs_n=1, address=0, rsp_valid=0.
- Write 0x000010/0xDEADBEEF/be=0xF:
  - as high 12 cycles; ws_n low exactly 8 cycles starting 2 cycles after as rises
  - rs_n stays 1 throughout
  - rsp_valid pulses once, 12 edges after accept
- Read 0x000004 with data_in=0xCAFEF00D, changed to 0x0 after the sampling edge: rsp_rdata = 0xCAFEF00D; data_out = 0.
- Back-to-back requests, req_valid held high: second accept occurs in the rsp_valid cycle; as low exactly 1 cycle between transactions.
- rst asserted in STROBE cycle 3: next edge ws_n=1, as=0, req_ready=1, no rsp_valid; the following request completes normally.
- Parameters 1/1/1: rsp_valid 3 edges after accept; strobe low exactly 1 cycle.
